sha256_core_arbiter: RTL and testbench
======================================

SHA256_CORE_ARBITER -- requirements
Module: sha256_core_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters, range 2..8.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 255: watchdog limit in cycles; 8-bit counter.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  NUM_REQ  per-requester request for one 512-bit block hash.
REQ-006 req_block  input  NUM_REQ x 512  per-requester padded message block, MSB = first word.
REQ-007 req_ready  output  NUM_REQ  one-hot accept strobe.
REQ-008 rsp_valid  output  NUM_REQ  one-hot response valid to the granted requester.
REQ-009 rsp_ready  input  NUM_REQ  per-requester response accept.
REQ-010 rsp_digest  output  256  digest for the requester flagged by rsp_valid.
REQ-011 rsp_err  output  1  response is a timeout abort.
REQ-012 grant_id  output  3  index of the current or last granted requester.
REQ-013 busy  output  1  high whenever the state is not IDLE.
REQ-014 core_start  output  1  single-cycle start pulse to the shared SHA-256 core.
REQ-015 core_block  output  512  block to the core; held stable from ISSUE until the response is consumed.
REQ-016 core_done  input  1  single-cycle completion pulse from the core.
REQ-017 core_digest  input  256  core result; valid in the core_done cycle only.

Function
REQ-018 SHALL implement four states: IDLE, ISSUE, WAIT, RESP.
REQ-019 IDLE: if any req_valid bit is high, SHALL grant the lowest index at or after rr_ptr, wrapping modulo NUM_REQ.
REQ-020 The grant cycle SHALL pulse req_ready[grant] for one cycle, register req_block[grant] into core_block, update grant_id and enter ISSUE.
REQ-021 ISSUE SHALL assert core_start for exactly one cycle, then enter WAIT.
REQ-022 core_start SHALL therefore follow the accepting req_ready pulse by exactly one cycle.
REQ-023 WAIT: on core_done, SHALL register core_digest into rsp_digest, clear rsp_err and enter RESP.
REQ-024 core_done SHALL be ignored in every state other than WAIT.
REQ-025 RESP SHALL hold rsp_valid[grant] and rsp_digest stable until rsp_ready[grant] is high.
REQ-026 On that handshake, SHALL drop rsp_valid, set rr_ptr = (grant+1) mod NUM_REQ and enter IDLE.
REQ-027 rsp_ready bits of non-granted requesters SHALL be ignored.
REQ-028 A req_valid that falls before being granted SHALL produce no transaction.
REQ-029 While not in IDLE, req_ready SHALL stay 0 and new requests SHALL wait.
REQ-030 Minimum turnaround SHALL be 1 IDLE cycle between responses.
REQ-031 Back-to-back requests from one requester SHALL be arbitrated fairly, with no starvation under continuous load.

Reset
REQ-032 When reset_n is sampled low, SHALL return to IDLE from any state, including mid-WAIT.
REQ-033 Reset values: rr_ptr=0, grant_id=0, all outputs 0, watchdog counter 0.
REQ-034 A core_done arriving after reset SHALL be ignored.

Configuration
REQ-035 Macro SHA256_ARB_TIMEOUT_EN defined: WAIT SHALL count cycles from entry.
REQ-036 With the macro defined, on reaching TIMEOUT_CYC cycles without core_done, SHALL enter RESP with rsp_err=1 and rsp_digest=0.
REQ-037 Macro undefined: no counter SHALL exist, rsp_err SHALL be tied 0 and WAIT SHALL wait indefinitely.

Structure
REQ-038 Package sha256_ctrl_pkg SHALL hold the state enum, BLOCK_W=512 and DIGEST_W=256.
REQ-039 The round-robin pick SHALL be a combinational sub-module sha256_rr_pick (inputs: request vector, pointer; outputs: valid, index).

Verification
REQ-040 Single request: req_valid[0], block "abc" padded (0x61626380..0018), behavioural core model with 130-cycle latency -> req_ready[0] pulse, core_start one cycle later, rsp_valid[0] with digest ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, rsp_err=0.
REQ-041 All four requesters valid at once from reset -> grants in order 0,1,2,3; grant_id sequence matches.
REQ-042 Requester 2 held continuously valid, requester 0 raised during the first transaction -> next grant goes to 0, then 2.
REQ-043 rsp_ready[1] withheld 20 cycles -> rsp_valid[1] and digest stable throughout; no new req_ready during that time.
REQ-044 reset_n low for 1 cycle mid-WAIT, then core_done -> IDLE, outputs 0, no rsp_valid.
REQ-045 With SHA256_ARB_TIMEOUT_EN and a core that never completes, TIMEOUT_CYC=10 -> rsp_valid with rsp_err=1 and digest 0, 10 cycles after WAIT entry.

Source files
------------

// File: rtl/sha256_ctrl_pkg.sv
// Shared types and widths for the SHA-256 core arbiter.
package sha256_ctrl_pkg;

  localparam int BLOCK_W  = 512;
  localparam int DIGEST_W = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/sha256_rr_pick.sv
// Combinational round-robin pick: lowest requesting index at or after ptr, wrapping.
module sha256_rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         ptr,
  output logic               valid,
  output logic [2:0]         idx
);

  logic [2*NUM_REQ-1:0] rot;
  logic [3:0]           sum;

  always_comb begin
    rot   = {req, req} >> ptr;
    valid = 1'b0;
    sum   = 4'd0;
    // Scan downward so the final hit is the one closest to ptr.
    for (int o = NUM_REQ - 1; o >= 0; o--) begin
      if (rot[o]) begin
        valid = 1'b1;
        sum   = {1'b0, ptr} + 4'(o);
      end
    end
    if (sum >= 4'(NUM_REQ)) sum = sum - 4'(NUM_REQ);
    idx = sum[2:0];
  end

endmodule

// File: rtl/sha256_core_arbiter.sv
// Round-robin arbiter sharing one SHA-256 block core between NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining SHA256_ARB_TIMEOUT_EN.
module sha256_core_arbiter
  import sha256_ctrl_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*BLOCK_W-1:0] req_block,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         rsp_valid,
  input  logic [NUM_REQ-1:0]         rsp_ready,
  output logic [DIGEST_W-1:0]        rsp_digest,
  output logic                       rsp_err,
  output logic [2:0]                 grant_id,
  output logic                       busy,
  output logic                       core_start,
  output logic [BLOCK_W-1:0]         core_block,
  input  logic                       core_done,
  input  logic [DIGEST_W-1:0]        core_digest,
  output logic [1:0]                 dbg_state
);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("NUM_REQ must be in 2..8");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be in 1..255");
  end

  arb_state_t           state;
  logic [2:0]           rr_ptr;
  logic                 pick_valid;
  logic [2:0]           pick_idx;
  logic [NUM_REQ-1:0]   pick_oh;
  logic [NUM_REQ-1:0]   grant_oh;
  logic [BLOCK_W-1:0]   pick_block;
  logic [2:0]           next_ptr;

  sha256_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    pick_oh    = '0;
    grant_oh   = '0;
    pick_block = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == 3'(i)) begin
        pick_oh[i] = 1'b1;
        pick_block = req_block[i*BLOCK_W +: BLOCK_W];
      end
      if (grant_id == 3'(i)) grant_oh[i] = 1'b1;
    end
  end

  assign next_ptr = (grant_id == 3'(NUM_REQ - 1)) ? 3'd0 : grant_id + 3'd1;

  // Handshakes: a request transfers in the cycle req_valid[i] && req_ready[i];
  // a response transfers in the cycle rsp_valid[i] && rsp_ready[i]. Both ready
  // and valid here are one-hot and only the granted lane is ever considered.
  assign req_ready  = (state == IDLE && reset_n && pick_valid) ? pick_oh : '0;
  assign rsp_valid  = (state == RESP) ? grant_oh : '0;
  assign busy       = (state != IDLE);
  assign core_start = (state == ISSUE);
  assign dbg_state  = state;

`ifdef SHA256_ARB_TIMEOUT_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] wd_cnt;
  logic       rsp_err_q;
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      rr_ptr     <= 3'd0;
      grant_id   <= 3'd0;
      core_block <= '0;
      rsp_digest <= '0;
`ifdef SHA256_ARB_TIMEOUT_EN
      wd_cnt     <= 8'd0;
      rsp_err_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant_id   <= pick_idx;
            core_block <= pick_block;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef SHA256_ARB_TIMEOUT_EN
          wd_cnt <= 8'd0;
`endif
          state  <= WAIT;
        end
        WAIT: begin
          if (core_done) begin
            rsp_digest <= core_digest;
`ifdef SHA256_ARB_TIMEOUT_EN
            rsp_err_q  <= 1'b0;
`endif
            state      <= RESP;
          end
`ifdef SHA256_ARB_TIMEOUT_EN
          else if (wd_cnt == WD_LAST) begin
            rsp_digest <= '0;
            rsp_err_q  <= 1'b1;
            state      <= RESP;
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
          end
`endif
        end
        RESP: begin
          if (|(rsp_ready & grant_oh)) begin
            rr_ptr <= next_ptr;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_core_arbiter.sv
// Bench for sha256_core_arbiter: SHA-256 core model, arbiter reference model, directed scenarios.
module tb_sha256_core_arbiter;

  localparam int NUM_REQ = 4;
`ifdef SHA256_ARB_TIMEOUT_EN
  localparam int TO_CYC   = 10;
  localparam int CORE_LAT = 5;
`else
  localparam int TO_CYC   = 255;
  localparam int CORE_LAT = 130;
`endif

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [255:0] H0 = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_DIGEST = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  logic                   clk;
  logic                   reset_n;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ*512-1:0] req_block;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ-1:0]     rsp_valid;
  logic [NUM_REQ-1:0]     rsp_ready;
  logic [255:0]           rsp_digest;
  logic                   rsp_err;
  logic [2:0]             grant_id;
  logic                   busy;
  logic                   core_start;
  logic [511:0]           core_block;
  logic                   core_done;
  logic [255:0]           core_digest;
  logic [1:0]             dbg_state;

  sha256_core_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_block(req_block),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_digest(rsp_digest), .rsp_err(rsp_err), .grant_id(grant_id), .busy(busy),
    .core_start(core_start), .core_block(core_block), .core_done(core_done),
    .core_digest(core_digest), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk;
  int n_fail;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- SHA-256 single-block reference ----------------
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha256_blk(input logic [511:0] b);
    logic [31:0] w [64];
    logic [31:0] h [8];
    logic [31:0] a, bb, c, d, e, f, g, hh, t1, t2, s0, s1;
    for (int i = 0; i < 8; i++) h[i] = H0[255-32*i -: 32];
    for (int i = 0; i < 16; i++) w[i] = b[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    a = h[0]; bb = h[1]; c = h[2]; d = h[3]; e = h[4]; f = h[5]; g = h[6]; hh = h[7];
    for (int i = 0; i < 64; i++) begin
      t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & bb) ^ (a & c) ^ (bb & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = bb; bb = a; a = t1 + t2;
    end
    return {h[0] + a, h[1] + bb, h[2] + c, h[3] + d, h[4] + e, h[5] + f, h[6] + g, h[7] + hh};
  endfunction

  function automatic logic [511:0] rnd_blk();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- requester and core drivers ----------------
  logic [NUM_REQ-1:0] keep_valid;
  logic [NUM_REQ-1:0] acc_seen;
  logic               core_hang;
  int                 pend;
  logic [511:0]       pend_blk;

  initial begin
    core_done   = 1'b0;
    core_digest = '0;
    pend        = 0;
    pend_blk    = '0;
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < NUM_REQ; i++)
        if (acc_seen[i] && !keep_valid[i]) req_valid[i] = 1'b0;
      core_done   = 1'b0;
      core_digest = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          core_done   = 1'b1;
          core_digest = sha256_blk(pend_blk);
        end
      end
      if (core_start && !core_hang) begin
        pend     = CORE_LAT;
        pend_blk = core_block;
      end
    end
  end

  // ---------------- reference model, monitor, per-cycle compare ----------------
  int          cyc_cnt, rr_cyc, cs_cyc, rv_rise, rv_cnt, hs_cnt;
  logic [2:0]  grant_log [$];

  function automatic int m_pick(input logic [NUM_REQ-1:0] v, input int ptr);
    for (int k = 0; k < NUM_REQ; k++)
      if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    return -1;
  endfunction

  initial begin : model
    int           m_ph;   // 0 idle, 1 issue, 2 wait, 3 resp
    int           m_ptr, m_gid, m_wc, p;
    logic [511:0] m_blk;
    logic [255:0] m_dig;
    logic         m_err, prev_rv;
    logic [NUM_REQ-1:0] e_rr, e_rv;
    m_ph = 0; m_ptr = 0; m_gid = 0; m_wc = 0; m_blk = '0; m_dig = '0; m_err = 1'b0;
    prev_rv = 1'b0;
    cyc_cnt = 0; rr_cyc = 0; cs_cyc = 0; rv_rise = 0; rv_cnt = 0; hs_cnt = 0;
    acc_seen = '0;
    forever begin
      @(negedge clk);
      cyc_cnt++;
      p    = m_pick(req_valid, m_ptr);
      e_rr = '0;
      if (m_ph == 0 && reset_n && p >= 0) e_rr[p] = 1'b1;
      e_rv = '0;
      if (m_ph == 3) e_rv[m_gid] = 1'b1;
      chk("req_ready", 256'(req_ready), 256'(e_rr));
      chk("rsp_valid", 256'(rsp_valid), 256'(e_rv));
      chk("core_start", 256'(core_start), 256'(m_ph == 1));
      chk("busy", 256'(busy), 256'(m_ph != 0));
      chk("grant_id", 256'(grant_id), 256'(m_gid));
      chk("core_block", 256'(core_block ^ m_blk), 256'(0));
      chk("rsp_digest", rsp_digest, m_dig);
      chk("rsp_err", 256'(rsp_err), 256'(m_err));

      acc_seen = req_ready;
      for (int i = 0; i < NUM_REQ; i++)
        if (req_ready[i]) begin
          grant_log.push_back(3'(i));
          rr_cyc = cyc_cnt;
        end
      if (core_start) cs_cyc = cyc_cnt;
      if (rsp_valid != '0 && !prev_rv) begin
        rv_rise = cyc_cnt;
        rv_cnt++;
      end
      prev_rv = (rsp_valid != '0);
      if ((rsp_valid & rsp_ready) != '0) hs_cnt++;

      if (!reset_n) begin
        m_ph = 0; m_ptr = 0; m_gid = 0; m_wc = 0; m_blk = '0; m_dig = '0; m_err = 1'b0;
      end else begin
        case (m_ph)
          0: if (p >= 0) begin m_gid = p; m_blk = req_block[p*512 +: 512]; m_ph = 1; end
          1: begin m_ph = 2; m_wc = 0; end
          2: begin
            if (core_done) begin m_dig = core_digest; m_err = 1'b0; m_ph = 3; end
`ifdef SHA256_ARB_TIMEOUT_EN
            else if (m_wc == TO_CYC - 1) begin m_dig = '0; m_err = 1'b1; m_ph = 3; end
            else m_wc++;
`endif
          end
          default: if (rsp_ready[m_gid]) begin m_ptr = (m_gid + 1) % NUM_REQ; m_ph = 0; end
        endcase
      end
    end
  end

  // ---------------- scenario helpers ----------------
  logic [2:0] exp_q [$];

  task automatic do_reset();
    reset_n = 1'b0;
    cyc(2);
    reset_n = 1'b1;
  endtask

  task automatic wait_hs(input int n, input int max_cyc, input string nm);
    int start;
    int k;
    start = hs_cnt;
    k = 0;
    while (hs_cnt < start + n && k < max_cyc) begin cyc(1); k++; end
    chk(nm, 256'(hs_cnt >= start + n), 256'(1));
  endtask

  task automatic wait_idle(input int max_cyc, input string nm);
    int k;
    k = 0;
    while ((busy || req_valid != '0) && k < max_cyc) begin cyc(1); k++; end
    chk(nm, 256'(busy), 256'(0));
  endtask

  task automatic wait_rsp(input int lane, input int max_cyc, input string nm);
    int k;
    k = 0;
    while (!rsp_valid[lane] && k < max_cyc) begin cyc(1); k++; end
    chk(nm, 256'(rsp_valid[lane]), 256'(1));
  endtask

  task automatic chk_grants(input string nm);
    chk({nm, "_len"}, 256'(grant_log.size() >= exp_q.size()), 256'(1));
    for (int i = 0; i < exp_q.size() && i < grant_log.size(); i++)
      chk(nm, 256'(grant_log[i]), 256'(exp_q[i]));
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    logic [511:0] blk;
    int           k;
    n_chk = 0; n_fail = 0;
    reset_n = 1'b0; req_valid = '0; req_block = '0; rsp_ready = '1;
    keep_valid = '0; core_hang = 1'b0;
    cyc(3);
    reset_n = 1'b1;
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_grant_id", 256'(grant_id), 256'(0));
    chk("rst_rsp_valid", 256'(rsp_valid), 256'(0));
    chk("rst_core_start", 256'(core_start), 256'(0));
    chk("rst_rsp_digest", rsp_digest, 256'(0));
    chk("rst_core_block", 256'(core_block == '0), 256'(1));

    // single "abc" request
    req_block[0 +: 512] = {32'h61626380, 416'h0, 64'h18};
    req_valid[0] = 1'b1;
    wait_rsp(0, CORE_LAT + 20, "abc_rsp_timeout");
    chk("abc_digest", rsp_digest, ABC_DIGEST);
    chk("abc_err", 256'(rsp_err), 256'(0));
    chk("start_after_ready", 256'(cs_cyc - rr_cyc), 256'(1));
    wait_idle(20, "abc_idle");

    // four requesters at once from reset
    do_reset();
    grant_log.delete(); exp_q = '{3'd0, 3'd1, 3'd2, 3'd3};
    for (int i = 0; i < NUM_REQ; i++) req_block[i*512 +: 512] = rnd_blk();
    req_valid = '1;
    wait_hs(4, 4 * (CORE_LAT + 10), "all4_done");
    chk_grants("all4_order");
    wait_idle(20, "all4_idle");

    // requester 2 continuous, 0 raised mid-transaction, 1 pulsed and withdrawn
    grant_log.delete(); exp_q = '{3'd2, 3'd0, 3'd2};
    req_block[2*512 +: 512] = rnd_blk();
    req_block[0 +: 512]     = rnd_blk();
    keep_valid[2] = 1'b1;
    req_valid[2]  = 1'b1;
    cyc(3);
    req_valid[0] = 1'b1;
    req_valid[1] = 1'b1;
    cyc(2);
    req_valid[1] = 1'b0;
    wait_hs(3, 3 * (CORE_LAT + 10), "fair_done");
    keep_valid[2] = 1'b0;
    req_valid[2]  = 1'b0;
    wait_idle(CORE_LAT + 20, "fair_idle");
    chk_grants("fair_order");

    // response back-pressure on requester 1
    grant_log.delete(); exp_q = '{3'd1, 3'd3};
    blk = rnd_blk();
    req_block[1*512 +: 512] = blk;
    req_block[3*512 +: 512] = rnd_blk();
    rsp_ready[1] = 1'b0;
    req_valid[1] = 1'b1;
    wait_rsp(1, CORE_LAT + 20, "hold_rsp_timeout");
    req_valid[3] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      chk("hold_rsp_valid", 256'(rsp_valid), 256'(4'b0010));
      chk("hold_digest", rsp_digest, sha256_blk(blk));
      chk("hold_no_ready", 256'(req_ready), 256'(0));
    end
    rsp_ready[1] = 1'b1;
    wait_hs(2, 2 * (CORE_LAT + 10), "hold_done");
    wait_idle(20, "hold_idle");
    chk_grants("hold_order");

    // reset in the middle of WAIT, core completes afterwards
    req_block[0 +: 512] = rnd_blk();
    req_valid[0] = 1'b1;
    k = 0;
    while (!core_start && k < 20) begin cyc(1); k++; end
    chk("midwait_start", 256'(core_start), 256'(1));
    cyc(3);
    reset_n = 1'b0;
    cyc(1);
    reset_n = 1'b1;
    chk("midwait_busy", 256'(busy), 256'(0));
    chk("midwait_grant_id", 256'(grant_id), 256'(0));
    chk("midwait_digest", rsp_digest, 256'(0));
    k = rv_cnt;
    cyc(CORE_LAT + 10);
    chk("midwait_no_rsp", 256'(rv_cnt), 256'(k));
    chk("midwait_still_idle", 256'(busy), 256'(0));

`ifdef SHA256_ARB_TIMEOUT_EN
    // watchdog abort with a core that never answers
    core_hang = 1'b1;
    req_block[2*512 +: 512] = rnd_blk();
    req_valid[2] = 1'b1;
    wait_rsp(2, TO_CYC + 20, "to_rsp_timeout");
    chk("to_err", 256'(rsp_err), 256'(1));
    chk("to_digest", rsp_digest, 256'(0));
    chk("to_lane", 256'(rsp_valid), 256'(4'b0100));
    chk("to_latency", 256'(rv_rise - (cs_cyc + 1)), 256'(10));
    wait_idle(20, "to_idle");
    core_hang = 1'b0;
`endif

    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
